// File: rtl/mem_access_arbiter.sv
// Round-robin arbiter sharing one single-port memory between NUM_REQ requesters.
// Define MEM_ARB_LOCK_EN to add per-requester lock inputs and an ARB/LOCKED FSM.
module mem_access_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int RD_LAT  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ-1:0]    we,
    input  logic [NUM_REQ*AW-1:0] addr,
    input  logic [NUM_REQ*DW-1:0] wdata,
`ifdef MEM_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]    lock,
`endif
    output logic [NUM_REQ-1:0]    gnt,
    output logic [NUM_REQ-1:0]    rvalid,
    output logic [DW-1:0]         rdata,
    output logic                  mem_write,
    output logic                  mem_read,
    output logic [AW-1:0]         mem_addr,
    output logic [DW-1:0]         mem_wdata,
    input  logic [DW-1:0]         mem_rdata
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        if (int'(i) == NUM_REQ - 1) begin
            return '0;
        end else begin
            return i + 1'b1;
        end
    endfunction

    logic [IW-1:0] ptr_q, ptr_d;
    logic          gnt_vld_s;
    logic [IW-1:0] gnt_idx_s;
    int            cand_s;

    logic          mem_write_q, mem_read_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic [IW-1:0] cmd_idx_q;
    logic          tag_vld_q [RD_LAT];
    logic [IW-1:0] tag_idx_q [RD_LAT];

`ifdef MEM_ARB_LOCK_EN
    typedef enum logic {ST_ARB = 1'b0, ST_LOCKED = 1'b1} state_t;
    state_t        state_q, state_d;
    logic [IW-1:0] owner_q, owner_d;
`endif

    // Arbitration: first requester at or after ptr wins; a lock owner blocks everyone else.
    always_comb begin
        gnt_vld_s = 1'b0;
        gnt_idx_s = '0;
        cand_s    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_s = (int'(ptr_q) + k) % NUM_REQ;
            if (!gnt_vld_s && req[IW'(cand_s)]) begin
                gnt_vld_s = 1'b1;
                gnt_idx_s = IW'(cand_s);
            end else begin
                gnt_vld_s = gnt_vld_s;
            end
        end
`ifdef MEM_ARB_LOCK_EN
        if (state_q == ST_LOCKED) begin
            gnt_vld_s = req[owner_q];
            gnt_idx_s = owner_q;
        end else begin
            gnt_vld_s = gnt_vld_s;
        end
`endif
        if (reset) begin
            gnt_vld_s = 1'b0;
        end else begin
            gnt_vld_s = gnt_vld_s;
        end
    end

    // One-hot grant decode.
    always_comb begin
        gnt = '0;
        if (gnt_vld_s) begin
            gnt[gnt_idx_s] = 1'b1;
        end else begin
            gnt = '0;
        end
    end

    // Pointer advance and optional lock FSM next state.
    always_comb begin
        ptr_d = ptr_q;
`ifdef MEM_ARB_LOCK_EN
        state_d = state_q;
        owner_d = owner_q;
        case (state_q)
            ST_ARB: begin
                if (gnt_vld_s) begin
                    ptr_d = next_idx(gnt_idx_s);
                    if (lock[gnt_idx_s]) begin
                        state_d = ST_LOCKED;
                        owner_d = gnt_idx_s;
                    end else begin
                        state_d = ST_ARB;
                    end
                end else begin
                    ptr_d = ptr_q;
                end
            end
            ST_LOCKED: begin
                if (!lock[owner_q]) begin
                    state_d = ST_ARB;
                    ptr_d   = next_idx(owner_q);
                end else begin
                    state_d = ST_LOCKED;
                end
            end
            default: begin
                state_d = ST_ARB;
            end
        endcase
`else
        if (gnt_vld_s) begin
            ptr_d = next_idx(gnt_idx_s);
        end else begin
            ptr_d = ptr_q;
        end
`endif
    end

`ifdef MEM_ARB_LOCK_EN
    // Lock FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_ARB;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end
`endif

    // Pointer, command stage and read tag pipeline.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q       <= '0;
            mem_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cmd_idx_q   <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                tag_vld_q[i] <= 1'b0;
                tag_idx_q[i] <= '0;
            end
        end else begin
            ptr_q       <= ptr_d;
            mem_write_q <= gnt_vld_s && we[gnt_idx_s];
            mem_read_q  <= gnt_vld_s && !we[gnt_idx_s];
            if (gnt_vld_s) begin
                mem_addr_q  <= addr[gnt_idx_s*AW +: AW];
                mem_wdata_q <= wdata[gnt_idx_s*DW +: DW];
                cmd_idx_q   <= gnt_idx_s;
            end else begin
                mem_addr_q  <= mem_addr_q;
            end
            // Tags enter with the issued mem_read so they emerge alongside mem_rdata.
            for (int i = RD_LAT - 1; i > 0; i--) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_idx_q[i] <= tag_idx_q[i-1];
            end
            tag_vld_q[0] <= mem_read_q;
            tag_idx_q[0] <= cmd_idx_q;
        end
    end

    // Read return routing, combinational from mem_rdata.
    always_comb begin
        rvalid = '0;
        rdata  = '0;
        if (tag_vld_q[RD_LAT-1]) begin
            rvalid[tag_idx_q[RD_LAT-1]] = 1'b1;
            rdata                       = mem_rdata;
        end else begin
            rdata = '0;
        end
    end

    assign mem_write = mem_write_q;
    assign mem_read  = mem_read_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: doc/mem_access_arbiter.md
Name: mem_access_arbiter

Overview:
- Round-robin arbiter that shares one single-port external memory between NUM_REQ requesters.
- Each accepted request becomes a single-cycle registered memory write or read command.
- Read data returning from memory is routed back to the originating requester after a fixed RD_LAT.
- Sits directly in front of the memory whose write/read/addr/wdata/rdata bus is monitored by the data-integrity checker.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- AW, 32, address width.
- DW, 32, data width.
- RD_LAT, 2, memory read latency in cycles from mem_read to mem_rdata valid (>=1).

Ports:
- clk  input  1  clock, all logic on posedge.
- reset  input  1  synchronous active-high reset.
- req  input  NUM_REQ  per-requester request.
- we  input  NUM_REQ  per-requester 1=write, 0=read.
- addr  input  NUM_REQ*AW  flattened addresses; requester i occupies [i*AW +: AW].
- wdata  input  NUM_REQ*DW  flattened write data; requester i occupies [i*DW +: DW].
- gnt  output  NUM_REQ  one-hot grant, combinational; transfer occurs when req[i]&&gnt[i].
- rvalid  output  NUM_REQ  one-hot read-return strobe.
- rdata  output  DW  read data, valid when any rvalid bit is set.
- mem_write  output  1  memory write command.
- mem_read  output  1  memory read command.
- mem_addr  output  AW  memory address.
- mem_wdata  output  DW  memory write data.
- mem_rdata  input  DW  memory read data, valid RD_LAT cycles after mem_read.

Behaviour:
- Clock is clk; reset is synchronous, active-high, named reset.
- Reset values: gnt=0, rvalid=0, rdata=0, mem_write=0, mem_read=0, mem_addr=0, mem_wdata=0, priority pointer ptr=0, tag pipeline cleared.
- While reset=1, gnt is forced to 0.
- Arbitration (combinational, every cycle):
  - Search req starting at index ptr, wrapping modulo NUM_REQ.
  - The first set bit gets gnt. At most one gnt bit is set.
  - gnt=0 when req=0.
- Pointer update on posedge: if requester g was granted, ptr <= (g+1) mod NUM_REQ. If no grant, ptr holds.
- Command stage (registered, latency 1):
  - In the cycle after grant to g: mem_write=we[g], mem_read=!we[g], mem_addr=addr[g], mem_wdata=wdata[g].
  - With no grant: mem_write=mem_read=0. mem_addr and mem_wdata hold their previous values.
  - mem_write and mem_read are never both 1.
- Read return:
  - A tag pipeline of depth RD_LAT carries {valid, requester index} alongside each mem_read.
  - When the tag emerges, rvalid[idx]=1 and rdata=mem_rdata in the same cycle (combinational from mem_rdata).
  - Total latency from a read grant to rvalid is RD_LAT+1 cycles.
- Throughput: one transfer per cycle, back-to-back reads pipelined. Up to RD_LAT reads may be in flight; no stall is required.
- Boundary conditions:
  - All requesters asserting continuously: grants rotate 0,1,..,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 cycles.
  - Write followed by a read to the same address from different requesters: ordering is grant order. The read returns the new data (memory is in-order).
  - A requester dropping req without a grant is legal; no transfer occurs.
  - Reset mid-operation: in-flight read tags are discarded, no rvalid is produced after reset deasserts, and ptr returns to 0.
  - rvalid and a new grant to the same requester in the same cycle are independent and both allowed.

Optional Feature:
- MEM_ARB_LOCK_EN adds input lock (NUM_REQ bits) and a two-state FSM: ARB and LOCKED.
- ARB state:
  - Normal round-robin.
  - If the granted requester g has lock[g]=1 at transfer, go to LOCKED with owner=g.
- LOCKED state:
  - Only the owner can be granted: gnt[owner]=req[owner]. All other requesters are blocked.
  - ptr does not advance.
  - Return to ARB on the first posedge where lock[owner]=0, after which ptr <= owner+1.
  - reset forces ARB.
- Without MEM_ARB_LOCK_EN: no lock port, no FSM, pure round-robin.

Test Plan:
- Single write then read: req0 writes addr=0x10 wdata=0xA5A5; next cycle req0 reads addr=0x10 -> mem_write=1 one cycle after gnt; rvalid[0]=1 with rdata=0xA5A5 RD_LAT+1 (3) cycles after the read grant.
- Fairness: req=2'b11 held 8 cycles, all reads -> gnt sequence 01,10,01,10,...; rvalid alternates requesters with matching mem_rdata.
- Idle pointer hold: grant to req1, then req=0 for 5 cycles, then req=2'b11 -> first grant to req0 (ptr=0 after wrap).
- Pipelined reads: req1 issues reads to addr 1,2,3 on consecutive cycles -> mem_read high 3 consecutive cycles; rvalid[1] high 3 consecutive cycles with data in address order.
- Reset mid-read: read granted, reset asserted 1 cycle later for 1 cycle -> no rvalid ever appears; gnt=0 during reset; ptr=0 afterwards.
- Lock (MEM_ARB_LOCK_EN): req0 lock=1 for 4 transfers while req1 is requesting -> gnt[1]=0 throughout; after lock drops, the next grant goes to req1.
